// File: rtl/skinny_sca_pkg.sv
// Shared definitions for the SKINNY side-channel-protected datapath.
// Holds the SubCells layer controller FSM encoding and the default sizes:
// the number of state bytes per layer and the ISW1 sbox8 latency.
package skinny_sca_pkg;

    localparam int SKINNY_NBYTES  = 16;
    localparam int SBOX8_ISW1_LAT = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EVAL  = 3'd2,
        CAPT  = 3'd3,
        DONE  = 3'd4
    } layer_state_e;

endpackage

// File: rtl/skinny_sbox8_isw1_layer_ctrl.sv
// SubCells layer sequencer for a two-share SKINNY state.
// Drives one shared, non-pipelined masked sbox8 over every state byte,
// byte 0 first, writing each result back into the byte it came from.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid / in_ready   state handshake from the round controller
//   st1_i, st0_i          input state shares, byte k at [8k+7:8k]
//   rnd_valid / rnd_ready refresh-mask handshake with the PRNG
//   rnd_i                 8-bit refresh mask
//   out_valid / out_ready result handshake to the consumer
//   st1_o, st0_o          result state shares (straight from state regs)
//   busy                  high whenever the sequencer is not idle
//   sb_si1, sb_si0, sb_r  registered sbox inputs (shares + mask)
//   sb_bo1, sb_bo0        sbox output shares
module skinny_sbox8_isw1_layer_ctrl
    import skinny_sca_pkg::*;
#(
    parameter int NBYTES   = SKINNY_NBYTES,
    parameter int SBOX_LAT = SBOX8_ISW1_LAT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [8*NBYTES-1:0] st1_i,
    input  logic [8*NBYTES-1:0] st0_i,
    input  logic                rnd_valid,
    output logic                rnd_ready,
    input  logic [7:0]          rnd_i,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [8*NBYTES-1:0] st1_o,
    output logic [8*NBYTES-1:0] st0_o,
    output logic                busy,
    output logic [7:0]          sb_si1,
    output logic [7:0]          sb_si0,
    output logic [7:0]          sb_r,
    input  logic [7:0]          sb_bo1,
    input  logic [7:0]          sb_bo0
);

    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int CW = $clog2(SBOX_LAT) + 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(NBYTES - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SBOX_LAT - 1);

    layer_state_e        state;
    logic [IW-1:0]       idx;
    logic [CW-1:0]       cnt;
    logic [8*NBYTES-1:0] st1_q;
    logic [8*NBYTES-1:0] st0_q;

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);
    // One mask per byte: the handshake only exists while fetching.
    assign rnd_ready = (state == FETCH) && rnd_valid;
    assign st1_o     = st1_q;
    assign st0_o     = st0_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= '0;
            cnt    <= '0;
            st1_q  <= '0;
            st0_q  <= '0;
            sb_si1 <= '0;
            sb_si0 <= '0;
            sb_r   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        st1_q <= st1_i;
                        st0_q <= st0_i;
                        idx   <= '0;
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    // Shares and mask move to the sbox on the same edge so the
                    // gadget never sees a new share with a stale mask.
                    if (rnd_valid) begin
                        sb_si1 <= st1_q[8*idx +: 8];
                        sb_si0 <= st0_q[8*idx +: 8];
                        sb_r   <= rnd_i;
                        cnt    <= '0;
                        state  <= EVAL;
                    end
                end
                EVAL: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state <= CAPT;
                    end
                end
                CAPT: begin
                    st1_q[8*idx +: 8] <= sb_bo1;
                    st0_q[8*idx +: 8] <= sb_bo0;
                    if (idx == IDX_LAST) begin
                        state <= DONE;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= FETCH;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        st1_q  <= '0;
                        st0_q  <= '0;
                        sb_si1 <= '0;
                        sb_si0 <= '0;
                        sb_r   <= '0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/skinny_sbox8_isw1_layer_ctrl.md
Name: skinny_sbox8_isw1_layer_ctrl

Overview:
Sequences one shared, non-pipelined ISW1 masked sbox8 instance across all bytes of a two-share 128-bit SKINNY state. It applies the SubCells layer in place, one byte at a time. For each byte it loads the byte's shares together with a fresh 8-bit refresh mask, holds them stable for the sbox latency, then writes the result back into the state. It sits between the round controller (state in/out handshake), the PRNG (mask handshake) and the external sbox instance.

Parameters:
NBYTES, 16, number of state bytes processed per layer invocation
SBOX_LAT, 8, clock edges the sbox needs with stable inputs before bo is correct

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  state shares on st1_i/st0_i are valid
in_ready  out  1  controller idle, can accept a state
st1_i  in  8*NBYTES  input state, share 1; byte k at [8k+7:8k]
st0_i  in  8*NBYTES  input state, share 0
rnd_valid  in  1  PRNG mask byte valid
rnd_ready  out  1  mask byte consumed this cycle
rnd_i  in  8  PRNG refresh mask
out_valid  out  1  substituted state available
out_ready  in  1  consumer accepts the result
st1_o  out  8*NBYTES  result state, share 1
st0_o  out  8*NBYTES  result state, share 0
busy  out  1  high in any state other than IDLE
sb_si1  out  8  sbox input, share 1 (registered)
sb_si0  out  8  sbox input, share 0 (registered)
sb_r  out  8  sbox refresh mask (registered)
sb_bo1  in  8  sbox output, share 1
sb_bo0  in  8  sbox output, share 0

Behaviour:
- Reset (async, rst_n=0): state=IDLE. Index, counter, state registers, sb_si1/sb_si0/sb_r all 0. in_ready=1; out_valid=rnd_ready=busy=0; st1_o=st0_o=0.
- st1_o/st0_o are driven directly from the internal state registers.
- FSM states:
  - IDLE:
    - in_ready=1.
    - On in_valid: latch st1_i/st0_i, idx=0, go FETCH.
  - FETCH:
    - rnd_ready = rnd_valid; combinational, at most one mask consumed per byte.
    - On rnd_valid: in the same edge, load sb_si1/sb_si0 with byte idx of both shares and load sb_r with rnd_i; cnt=0; go EVAL.
    - Otherwise stay in FETCH with sb_* unchanged.
  - EVAL:
    - cnt increments each cycle.
    - When cnt==SBOX_LAT-1, go CAPT.
    - sb_* held constant.
  - CAPT:
    - sb_bo1/sb_bo0 are correct in this cycle; write them into byte idx of the respective shares.
    - If idx==NBYTES-1, go DONE; else idx++ and go FETCH.
    - sb_* still held.
  - DONE:
    - out_valid=1, held until out_ready.
    - On out_ready: clear the state registers and sb_* to 0, go IDLE.
- Share isolation: sb_si and sb_r change only together, and only on the FETCH handshake edge. Shares are never combined (XORed) inside this block.
- Latency with rnd_valid constantly 1:
  - SBOX_LAT+2 cycles per byte.
  - out_valid rises NBYTES*(SBOX_LAT+2) = 160 cycles after the accept edge.
  - Each rnd_valid=0 cycle in FETCH adds exactly one cycle.
- Byte order: byte 0 first, ascending. Each result lands in the same byte position it came from.
- in_valid outside IDLE is ignored, since in_ready=0. out_ready outside DONE is ignored.
- In DONE, out_valid and out_ready high in the same cycle as in_valid: return to IDLE only; the new state is accepted on a later cycle.
- rst_n asserted mid-operation: immediate return to reset values, with the partial state discarded. No rnd_ready pulse is produced during reset.
- Counter widths: idx is $clog2(NBYTES) bits; cnt is $clog2(SBOX_LAT)+1 bits. No wrap occurs beyond the compare values.

Decomposition:
- Shared package skinny_sca_pkg holds:
  - the FSM state enum (IDLE, FETCH, EVAL, CAPT, DONE);
  - the constants SKINNY_NBYTES=16 and SBOX8_ISW1_LAT=8.
- The sbox instance stays outside this block so the wrapper can swap gadget variants.
- A thin wrapper skinny_sbox8_isw1_layer (controller + skinny_sbox8_isw1_bypass_non_pipelined) is the natural companion for integration and test.

Test Plan:
- Reset check: hold rst_n=0, then release.
  - Required: in_ready=1, out_valid=0, rnd_ready=0, sb_* =0, st*_o=0.
- Unmasked all-zero state: st0=st1=0, rnd_valid=1, random masks.
  - Required: out_valid exactly 160 cycles after accept; st1_o^st0_o = 0x65 in every byte.
- Masked all-ones state: st0_i=random M, st1_i=M^{16{0xFF}}.
  - Required: st1_o^st0_o = all 0xFF; st0_o differs from a mask-free run.
- Mask starvation: deassert rnd_valid for 3 cycles at byte 5's FETCH.
  - Required: sb_* stays constant during the stall; total latency is 163 cycles; result unchanged.
  - Required: exactly 16 rnd_ready pulses, each coincident with rnd_valid.
- Mid-operation reset: pulse rst_n low during EVAL of byte 9.
  - Required: immediate reset values; a new state processed afterwards gives a correct result.
- Output backpressure: hold out_ready=0 for 10 cycles with in_valid=1 throughout.
  - Required: out_valid and st*_o stable, in_ready=0.
  - Required: after out_ready, IDLE, then the next state is accepted one cycle later.
